// File: rtl/sio_pkg.sv
// Shared SIO constants: UART framing defaults and receiver state encoding.
// Imported by sio_uart_rx and, later, sio_uart_tx.
package sio_pkg;

  localparam int SIO_OVERSAMPLE = 4;
  localparam int SIO_DATA_BITS  = 8;

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] START = 3'd1;
  localparam logic [2:0] DATA  = 3'd2;
  localparam logic [2:0] STOP  = 3'd3;
  localparam logic [2:0] BREAK = 3'd4;

endpackage

// File: rtl/sio_tick_edge.sv
// Rising-edge detector turning the divider square wave into a
// one-clk sample tick.
module sio_tick_edge (
  input  logic clk,
  input  logic rst,
  input  logic sio_clk,
  output logic tick
);

  logic sio_clk_d;

  always_ff @(posedge clk) begin
    if (rst) sio_clk_d <= 1'b0;
    else     sio_clk_d <= sio_clk;
  end

  assign tick = sio_clk & ~sio_clk_d;

endmodule

// File: rtl/sio_uart_rx.sv
// 8N1 UART receiver with oversampled mid-bit sampling and a
// single-entry valid/ack holding register.
module sio_uart_rx
  import sio_pkg::*;
#(
  parameter int OVERSAMPLE = SIO_OVERSAMPLE,
  parameter int DATA_BITS  = SIO_DATA_BITS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 sio_clk,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ack,
  output logic                 frame_err,
  output logic                 overrun
);

  localparam int TW   = $clog2(OVERSAMPLE + 1);
  localparam int BW   = $clog2(DATA_BITS + 1);
  localparam int HALF = OVERSAMPLE / 2;

  logic                 tick;
  logic [1:0]           rxd_sync;
  logic                 rxd_s;
  logic [2:0]           state;
  logic [TW-1:0]        tcnt;
  logic [BW-1:0]        bcnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 complete;
  logic                 take;

  sio_tick_edge u_tick (
    .clk     (clk),
    .rst     (rst),
    .sio_clk (sio_clk),
    .tick    (tick)
  );

  // Resets to idle-high so no phantom start bit follows reset
  always_ff @(posedge clk) begin
    if (rst) rxd_sync <= 2'b11;
    else     rxd_sync <= {rxd_sync[0], rxd};
  end

  assign rxd_s = rxd_sync[1];

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      tcnt  <= '0;
      bcnt  <= '0;
      shreg <= '0;
    end else if (tick) begin
      case (state)
        IDLE: begin
          if (!rxd_s) begin
            state <= START;
            tcnt  <= TW'(1);
          end
        end
        START: begin
          if (tcnt == TW'(HALF - 1)) begin
            state <= rxd_s ? IDLE : DATA;
            tcnt  <= '0;
            bcnt  <= '0;
          end else begin
            tcnt <= tcnt + TW'(1);
          end
        end
        DATA: begin
          if (tcnt == TW'(OVERSAMPLE - 1)) begin
            shreg <= {rxd_s, shreg[DATA_BITS-1:1]};
            tcnt  <= '0;
            if (bcnt == BW'(DATA_BITS - 1)) begin
              state <= STOP;
              bcnt  <= '0;
            end else begin
              bcnt <= bcnt + BW'(1);
            end
          end else begin
            tcnt <= tcnt + TW'(1);
          end
        end
        STOP: begin
          if (tcnt == TW'(OVERSAMPLE - 1)) begin
            state <= rxd_s ? IDLE : BREAK;
            tcnt  <= '0;
          end else begin
            tcnt <= tcnt + TW'(1);
          end
        end
        BREAK: begin
          if (rxd_s) state <= IDLE;
        end
        default: begin
          state <= IDLE;
          tcnt  <= '0;
          bcnt  <= '0;
        end
      endcase
    end
  end

  assign complete = tick && (state == STOP)
                 && (tcnt == TW'(OVERSAMPLE - 1));
  assign take = rx_valid && rx_ack;

  // A completion only lands in the register if it is free or
  // being emptied this very cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else if (complete) begin
      if (!rx_valid || rx_ack) begin
        rx_data   <= shreg;
        rx_valid  <= 1'b1;
        frame_err <= ~rxd_s;
        overrun   <= 1'b0;
      end else begin
        overrun <= 1'b1;
      end
    end else if (take) begin
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sio_uart_rx.sv
// Scoreboard bench for sio_uart_rx: frames driven tick by tick,
// expected bytes queued at stop-sample time, checked on handshake.
module tb_sio_uart_rx;
  import sio_pkg::*;

  typedef struct packed {
    logic [7:0] data;
    logic       fe;
    logic       ovr;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       sio_clk;
  logic       rxd;
  logic       rx_ack;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       overrun;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  sio_uart_rx dut (
    .clk       (clk),
    .rst       (rst),
    .sio_clk   (sio_clk),
    .rxd       (rxd),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ack    (rx_ack),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  // Model divider: 8 clk per tick
  initial begin
    sio_clk = 1'b0;
    forever begin
      repeat (4) @(negedge clk);
      sio_clk = ~sio_clk;
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every accepted handshake consumes the queue head
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (rx_valid && rx_ack) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_byte: got %0h expected none", rx_data);
        end else begin
          e = q.pop_front();
          chk("sb_data", rx_data, e.data);
          chk("sb_frame_err", frame_err, e.fe);
          chk("sb_overrun", overrun, e.ovr);
        end
      end
    end
  end

  // Holding-register behaviour at the stop-sample tick
  task automatic model_complete(logic [7:0] d, logic fe, logic ack);
    exp_t e;
    if (q.size() == 0 || ack) begin
      e = '{data: d, fe: fe, ovr: 1'b0};
      q.push_back(e);
    end else begin
      e = q[q.size()-1];
      e.ovr = 1'b1;
      q[q.size()-1] = e;
    end
  endtask

  // Entered just after a falling sio_clk; each n covers one tick
  task automatic seg(logic v, int n);
    rxd = v;
    repeat (n) @(negedge sio_clk);
  endtask

  task automatic send_frame(logic [7:0] d, logic stop, logic ack37);
    logic [8:0] bits;
    bits = {d, 1'b0};
    for (int i = 0; i < 9; i++) seg(bits[i], 4);
    rxd = stop;
    for (int i = 0; i < 4; i++) begin
      @(posedge sio_clk);
      if (i == 1) begin
        model_complete(d, ~stop, ack37);
        if (ack37) begin
          rx_ack = 1'b1;
          @(negedge clk);
          rx_ack = 1'b0;
        end
      end
      @(negedge sio_clk);
    end
  endtask

  task automatic post_check(string tag);
    chk({tag, "_valid"}, rx_valid, q.size() > 0);
    if (q.size() > 0) begin
      chk({tag, "_data"}, rx_data, q[0].data);
      chk({tag, "_fe"}, frame_err, q[0].fe);
      chk({tag, "_ovr"}, overrun, q[0].ovr);
    end
  endtask

  task automatic ack_byte();
    int n;
    n = 0;
    while (!rx_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("valid_wait", rx_valid, 1);
    repeat ($urandom_range(0, 4)) @(negedge clk);
    chk("valid_hold", rx_valid, 1);
    rx_ack = 1'b1;
    @(negedge clk);
    rx_ack = 1'b0;
    #2;
    chk("valid_drop", rx_valid, 0);
    @(negedge sio_clk);
  endtask

  task automatic chk_reset(string tag);
    chk({tag, "_valid"}, rx_valid, 0);
    chk({tag, "_data"}, rx_data, 0);
    chk({tag, "_fe"}, frame_err, 0);
    chk({tag, "_ovr"}, overrun, 0);
    chk({tag, "_state"}, dut.state, IDLE);
  endtask

  initial begin
    logic [9:0] bits;
    logic [7:0] d;
    logic       stop;
    int         mode;

    rxd    = 1'b1;
    rx_ack = 1'b0;
    rst    = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #2;
    chk_reset("reset");
    @(negedge sio_clk);
    seg(1'b1, 4);

    send_frame(8'h55, 1'b1, 1'b0);
    post_check("clean55");
    ack_byte();

    send_frame(8'hA3, 1'b1, 1'b0);
    post_check("b2b_a3");
    ack_byte();
    send_frame(8'h0F, 1'b1, 1'b0);
    post_check("b2b_0f");
    ack_byte();

    seg(1'b0, 1);
    seg(1'b1, 4);
    chk("glitch_valid", rx_valid, 0);
    send_frame(8'h3C, 1'b1, 1'b0);
    post_check("after_glitch");
    ack_byte();

    send_frame(8'hFF, 1'b0, 1'b0);
    post_check("break_ff");
    ack_byte();
    seg(1'b0, 16);
    chk("break_valid", rx_valid, 0);
    seg(1'b1, 4);
    send_frame(8'h12, 1'b1, 1'b0);
    post_check("after_break");
    ack_byte();

    send_frame(8'h11, 1'b1, 1'b0);
    seg(1'b1, 2);
    send_frame(8'h22, 1'b1, 1'b0);
    post_check("overrun");
    ack_byte();
    send_frame(8'h33, 1'b1, 1'b0);
    seg(1'b1, 2);
    send_frame(8'h44, 1'b1, 1'b1);
    post_check("ack_same");
    ack_byte();

    seg(1'b1, 4);
    bits = {1'b1, 8'hF0, 1'b0};
    for (int i = 0; i < 5; i++) seg(bits[i], 4);
    rxd = 1'b1;
    @(posedge sio_clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #2;
    chk_reset("midrst");
    q.delete();
    @(negedge sio_clk);
    seg(1'b1, 19);
    chk("midrst_idle", rx_valid, 0);
    send_frame(8'h81, 1'b1, 1'b0);
    post_check("after_rst");
    ack_byte();

    for (int k = 0; k < 40; k++) begin
      d    = 8'($urandom);
      stop = ($urandom_range(0, 5) != 0);
      mode = $urandom_range(0, 3);
      send_frame(d, stop, mode == 3);
      post_check("rand");
      if (mode < 2 && q.size() > 0) ack_byte();
      seg(1'b1, $urandom_range(1, 3));
    end
    if (q.size() > 0) ack_byte();
    chk("queue_empty", q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
